axi4l_slave_regfile: RTL

- Parametrised AXI4-lite slave with both write and read channels, backed by NUM_REGS x DATA_WIDTH registers.
- Supports byte strobes, independent AW/W arrival order and decode-error responses.
- Emits the one-cycle register-file write notification (axi4l_wdata/axi4l_waddr/axi4l_wvalid) consumed by downstream register logic.
- Sits between the AXI4-lite interconnect and the block's control/status registers.

---
 rtl/axi4l_slave_regfile.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/axi4l_slave_regfile.sv
// rtl/axi4l_slave_regfile.sv - AXI4-lite slave backed by a flat register file
// Independent write (idle/commit/resp) and read (idle/resp) machines; all outputs registered.
module axi4l_slave_regfile #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           axi4l_clock,
    input  logic                           axi_areset,
    input  logic [ADDR_WIDTH-1:0]          axi_awaddr,
    input  logic [2:0]                     axi_awprot,
    input  logic                           axi_awaddr_valid,
    output logic                           axi_awaddr_ready,
    input  logic [DATA_WIDTH-1:0]          axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        axi_wstrb,
    input  logic                           axi_wdata_valid,
    output logic                           axi_wdata_ready,
    output logic [1:0]                     axi_bresp,
    output logic                           axi_bvalid,
    input  logic                           axi_bready,
    input  logic [ADDR_WIDTH-1:0]          axi_araddr,
    input  logic [2:0]                     axi_arprot,
    input  logic                           axi_araddr_valid,
    output logic                           axi_araddr_ready,
    output logic [DATA_WIDTH-1:0]          axi_rdata,
    output logic [1:0]                     axi_rresp,
    output logic                           axi_rvalid,
    input  logic                           axi_rready,
    output logic [DATA_WIDTH-1:0]          axi4l_wdata,
    output logic [ADDR_WIDTH-1:0]          axi4l_waddr,
    output logic                           axi4l_wvalid,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LSB        = $clog2(STRB_WIDTH);
    localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] NREGS_A = ADDR_WIDTH'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_RESP} rstate_t;

    wstate_t                 r_wstate;
    rstate_t                 r_rstate;
    logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
    logic                    r_awaddr_ready;
    logic                    r_wdata_ready;
    logic                    r_aw_have;
    logic                    r_w_have;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata_q;
    logic [STRB_WIDTH-1:0]   r_wstrb_q;
    logic                    r_bvalid;
    logic [1:0]              r_bresp;
    logic [DATA_WIDTH-1:0]   r_notify_data;
    logic [ADDR_WIDTH-1:0]   r_notify_addr;
    logic                    r_notify_valid;
    logic                    r_araddr_ready;
    logic                    r_rvalid;
    logic [1:0]              r_rresp;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic                    w_aw_fire;
    logic                    w_w_fire;
    logic                    w_ar_fire;
    logic [ADDR_WIDTH-1:0]   w_aw_index;
    logic [ADDR_WIDTH-1:0]   w_ar_index;
    logic                    w_aw_hit;
    logic                    w_ar_hit;
    logic [IDX_W-1:0]        w_aw_sel;
    logic [IDX_W-1:0]        w_ar_sel;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic                    w_unused;

    assign w_aw_fire  = axi_awaddr_valid && r_awaddr_ready;
    assign w_w_fire   = axi_wdata_valid && r_wdata_ready;
    assign w_ar_fire  = axi_araddr_valid && r_araddr_ready;
    assign w_aw_index = r_awaddr >> LSB;
    assign w_ar_index = axi_araddr >> LSB;
    assign w_aw_hit   = (w_aw_index < NREGS_A);
    assign w_ar_hit   = (w_ar_index < NREGS_A);
    assign w_aw_sel   = w_aw_index[IDX_W-1:0];
    assign w_ar_sel   = w_ar_index[IDX_W-1:0];
    assign w_unused   = ^{axi_awprot, axi_arprot};

    always_comb begin
        w_merged = r_regs[w_aw_sel];
        for (int k = 0; k < STRB_WIDTH; k++) begin
            if (r_wstrb_q[k]) begin
                w_merged[k*8 +: 8] = r_wdata_q[k*8 +: 8];
            end
        end
    end

    // AW and W are captured independently; commit starts once both are held.
    always_ff @(posedge axi4l_clock or posedge axi_areset) begin
        if (axi_areset) begin
            r_wstate       <= W_IDLE;
            r_awaddr_ready <= 1'b0;
            r_wdata_ready  <= 1'b0;
            r_aw_have      <= 1'b0;
            r_w_have       <= 1'b0;
            r_awaddr       <= '0;
            r_wdata_q      <= '0;
            r_wstrb_q      <= '0;
            r_bvalid       <= 1'b0;
            r_bresp        <= RESP_OKAY;
            r_notify_data  <= '0;
            r_notify_addr  <= '0;
            r_notify_valid <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VALUE;
            end
        end else begin
            r_notify_valid <= 1'b0;
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_fire) begin
                        r_awaddr  <= axi_awaddr;
                        r_aw_have <= 1'b1;
                    end
                    if (w_w_fire) begin
                        r_wdata_q <= axi_wdata;
                        r_wstrb_q <= axi_wstrb;
                        r_w_have  <= 1'b1;
                    end
                    if ((r_aw_have || w_aw_fire) && (r_w_have || w_w_fire)) begin
                        r_wstate       <= W_COMMIT;
                        r_awaddr_ready <= 1'b0;
                        r_wdata_ready  <= 1'b0;
                    end else begin
                        r_awaddr_ready <= !(r_aw_have || w_aw_fire);
                        r_wdata_ready  <= !(r_w_have || w_w_fire);
                    end
                end
                W_COMMIT: begin
                    if (w_aw_hit) begin
                        r_regs[w_aw_sel] <= w_merged;
                        r_notify_valid   <= 1'b1;
                        r_notify_data    <= w_merged;
                        r_notify_addr    <= r_awaddr;
                        r_bresp          <= RESP_OKAY;
                    end else begin
                        r_bresp          <= RESP_DECERR;
                    end
                    r_bvalid <= 1'b1;
                    r_wstate <= W_RESP;
                end
                W_RESP: begin
                    if (axi_bready) begin
                        r_bvalid       <= 1'b0;
                        r_aw_have      <= 1'b0;
                        r_w_have       <= 1'b0;
                        r_awaddr_ready <= 1'b1;
                        r_wdata_ready  <= 1'b1;
                        r_wstate       <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Reads sample the register array before any same-edge commit lands.
    always_ff @(posedge axi4l_clock or posedge axi_areset) begin
        if (axi_areset) begin
            r_rstate       <= R_IDLE;
            r_araddr_ready <= 1'b0;
            r_rvalid       <= 1'b0;
            r_rresp        <= RESP_OKAY;
            r_rdata        <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_fire) begin
                        r_rdata        <= w_ar_hit ? r_regs[w_ar_sel] : '0;
                        r_rresp        <= w_ar_hit ? RESP_OKAY : RESP_DECERR;
                        r_rvalid       <= 1'b1;
                        r_araddr_ready <= 1'b0;
                        r_rstate       <= R_RESP;
                    end else begin
                        r_araddr_ready <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (axi_rready) begin
                        r_rvalid       <= 1'b0;
                        r_araddr_ready <= 1'b1;
                        r_rstate       <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign axi_awaddr_ready = r_awaddr_ready;
    assign axi_wdata_ready  = r_wdata_ready;
    assign axi_bvalid       = r_bvalid;
    assign axi_bresp        = r_bresp;
    assign axi_araddr_ready = r_araddr_ready;
    assign axi_rvalid       = r_rvalid;
    assign axi_rresp        = r_rresp;
    assign axi_rdata        = r_rdata;
    assign axi4l_wdata      = r_notify_data;
    assign axi4l_waddr      = r_notify_addr;
    assign axi4l_wvalid     = r_notify_valid;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end

endmodule
